// File: rtl/enigma_stream_if.sv
// Code-word / output stream bundle for enigma_stream.
// The master side is the host plus the downstream consumer; the slave side is the cipher core.
interface enigma_stream_if #(
    parameter int SYM_W = 6
) ();
    logic             in_valid;
    logic             crypt_mode;
    logic             in_valid_2;
    logic             in_last;
    logic [SYM_W-1:0] code_in;
    logic             in_ready;
    logic             out_valid;
    logic [SYM_W-1:0] out_code;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_valid, crypt_mode, in_valid_2, in_last, code_in, out_ready,
        input  in_ready, out_valid, out_code, out_last
    );

    modport slave (
        input  in_valid, crypt_mode, in_valid_2, in_last, code_in, out_ready,
        output in_ready, out_valid, out_code, out_last
    );
endinterface

// File: rtl/enigma_stream.sv
// Two-rotor Enigma stream cipher over a 2^SYM_W alphabet.
// It loads its rotor tables through a 2N-beat burst and uses a two-stage valid/ready pipeline.
module enigma_stream #(
    parameter int SYM_W  = 6,
    parameter int STEP_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    enigma_stream_if.slave bus
);
    localparam int N     = 1 << SYM_W;
    localparam int CNT_W = SYM_W + 2;

    typedef logic [SYM_W-1:0] sym_t;

    sym_t a_rot_q [N];
    sym_t a_rot_d [N];
    sym_t a_inv_q [N];
    sym_t a_inv_d [N];
    sym_t b_rot_q [N];
    sym_t b_rot_d [N];
    sym_t b_inv_q [N];
    sym_t b_inv_d [N];

    logic [2:0] pos_q [8];
    logic [2:0] pos_d [8];
    sym_t       shift_q, shift_d;
    logic       mode_q, mode_d;

    logic             load_act_q, load_act_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic s1_valid_q, s1_valid_d;
    sym_t s1_code_q, s1_code_d;
    logic s1_last_q, s1_last_d;
    logic out_valid_q, out_valid_d;
    sym_t out_code_q, out_code_d;
    logic out_last_q, out_last_d;

    // P_m packed with P_m[0] in the top octal digit.
    function automatic logic [2:0] perm_src(input logic [2:0] m, input logic [2:0] k);
        logic [7:0][2:0] row;
        case (m)
            3'd0:    row = 24'o01234567;
            3'd1:    row = 24'o10325476;
            3'd2:    row = 24'o23016745;
            3'd3:    row = 24'o04561237;
            3'd4:    row = 24'o45670123;
            3'd5:    row = 24'o56734012;
            3'd6:    row = 24'o67325401;
            default: row = 24'o76543210;
        endcase
        return row[3'd7 - k];
    endfunction

    sym_t       dp_x, dp_a, dp_b_idx, dp_b, dp_r, dp_bi, dp_ai, dp_y, dp_step;
    logic [2:0] dp_c, dp_m;

    always_comb begin
        dp_x     = s1_code_q - shift_q;
        dp_a     = a_rot_q[dp_x];
        dp_b_idx = dp_a;
        dp_b_idx[2:0] = pos_q[dp_a[2:0]];
        dp_b     = b_rot_q[dp_b_idx];
        dp_r     = ~dp_b;
        dp_bi    = b_inv_q[dp_r];
        // pos is always a permutation; scanning downward leaves the smallest match in dp_c.
        dp_c     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pos_q[k] == dp_bi[2:0]) dp_c = 3'(k);
        end
        dp_ai    = dp_bi;
        dp_ai[2:0] = dp_c;
        dp_y     = a_inv_q[dp_ai] + shift_q;
        dp_step  = '0;
        dp_step[STEP_W-1:0] = mode_q ? dp_ai[STEP_W-1:0] : dp_a[STEP_W-1:0];
        dp_m     = mode_q ? dp_r[2:0] : dp_b[2:0];
    end

    logic             s2_free, advance, in_ready, accept, load_start;
    logic [CNT_W-1:0] beat;
    sym_t             beat_sym;

    always_comb begin
        a_rot_d     = a_rot_q;
        a_inv_d     = a_inv_q;
        b_rot_d     = b_rot_q;
        b_inv_d     = b_inv_q;
        pos_d       = pos_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        load_act_d  = bus.in_valid;
        beat_d      = beat_q;
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_last_d  = out_last_q;

        s2_free    = !out_valid_q || bus.out_ready;
        advance    = s1_valid_q && s2_free;
        in_ready   = !bus.in_valid && (!s1_valid_q || s2_free);
        accept     = bus.in_valid_2 && in_ready;
        load_start = bus.in_valid && !load_act_q;
        beat       = load_start ? '0 : beat_q;
        beat_sym   = beat[SYM_W-1:0];

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = bus.code_in;
            s1_last_d  = bus.in_last;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (advance) begin
            out_valid_d = 1'b1;
            out_code_d  = dp_y;
            out_last_d  = s1_last_q;
            if (s1_last_q) begin
                shift_d = '0;
                for (int k = 0; k < 8; k++) pos_d[k] = 3'(k);
            end else begin
                shift_d = shift_q + dp_step;
                for (int k = 0; k < 8; k++) pos_d[k] = pos_q[perm_src(dp_m, 3'(k))];
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Beats past 2N in one burst are ignored; the counter parks at 2N.
        if (bus.in_valid) begin
            if (!beat[SYM_W+1]) begin
                if (!beat[SYM_W]) begin
                    a_rot_d[beat_sym]    = bus.code_in;
                    a_inv_d[bus.code_in] = beat_sym;
                end else begin
                    b_rot_d[beat_sym]    = bus.code_in;
                    b_inv_d[bus.code_in] = beat_sym;
                end
                beat_d = beat + CNT_W'(1);
            end else begin
                beat_d = beat;
            end
            if (load_start) begin
                mode_d  = bus.crypt_mode;
                shift_d = '0;
                for (int k = 0; k < 8; k++) pos_d[k] = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                a_rot_q[i] <= '0;
                a_inv_q[i] <= '0;
                b_rot_q[i] <= '0;
                b_inv_q[i] <= '0;
            end
            for (int k = 0; k < 8; k++) pos_q[k] <= 3'(k);
            shift_q     <= '0;
            mode_q      <= 1'b0;
            load_act_q  <= 1'b0;
            beat_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            a_rot_q     <= a_rot_d;
            a_inv_q     <= a_inv_d;
            b_rot_q     <= b_rot_d;
            b_inv_q     <= b_inv_d;
            pos_q       <= pos_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            load_act_q  <= load_act_d;
            beat_q      <= beat_d;
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.out_last  = out_last_q;
endmodule
